// File: rtl/floppy_track_loader_if.sv
// SD block handshake between the track loader and the SD/buffer side.
//   sd_lba     : LBA of the current sector request
//   sd_rd      : read request (held until the ack rises)
//   sd_wr      : write request (held until the ack rises)
//   sd_ack     : transfer-in-progress acknowledge from the SD side
//   buf_sector : sector slot in the track buffer; RAM address is {buf_sector, sd_buff_addr}
interface floppy_track_loader_if;
    logic [31:0] sd_lba;
    logic        sd_rd;
    logic        sd_wr;
    logic        sd_ack;
    logic [3:0]  buf_sector;

    modport master (output sd_lba, output sd_rd, output sd_wr, output buf_sector, input sd_ack);
    modport slave  (input sd_lba, input sd_rd, input sd_wr, input buf_sector, output sd_ack);
endinterface

// File: rtl/floppy_track_loader.sv
// Keeps one track of the mounted floppy image resident in the track buffer.
// On a track or image change it writes back a dirty track, then fetches the
// new one a sector at a time over the SD handshake, stalling the CPU meanwhile.
// Ports:
//   clk_sys, reset    : clock, synchronous active-high reset
//   track             : head position requested by the disk controller
//   fd_write_disk     : controller wrote into the track buffer (marks dirty)
//   img_mounted       : one-cycle (re)mount pulse; img_size==0 means eject
//   img_size          : size of the mounted image
//   img_readonly      : write protect, sampled on img_mounted
//   sd                : SD request/ack handshake plus buffer sector index
//   cpu_wait          : CPU stall while not idle
//   dirty             : resident track has unsaved writes
//
// state   | meaning
// IDLE    | track resident (or nothing mounted), watching for a change
// WB_REQ  | write request for sector buf_sector of cur_track, waiting ack rise
// WB_XFER | write-back sector in flight, waiting ack fall
// RD_REQ  | read request for sector buf_sector of tgt, waiting ack rise
// RD_XFER | read sector in flight, waiting ack fall
module floppy_track_loader #(
    parameter int SECTORS = 13,
    parameter int TRACK_W = 6
) (
    input  logic                 clk_sys,
    input  logic                 reset,
    input  logic [TRACK_W-1:0]   track,
    input  logic                 fd_write_disk,
    input  logic                 img_mounted,
    input  logic [63:0]          img_size,
    input  logic                 img_readonly,
    floppy_track_loader_if.master sd,
    output logic                 cpu_wait,
    output logic                 dirty
);
    typedef enum logic [2:0] {IDLE, WB_REQ, WB_XFER, RD_REQ, RD_XFER} state_t;

    localparam logic [3:0] LAST_SECTOR = 4'(SECTORS - 1);

    state_t             state_q;
    logic               ack_q;
    logic               mounted_q, valid_q, ro_q, dirty_q, abort_q;
    logic               cpu_wait_q, sd_rd_q, sd_wr_q;
    logic [TRACK_W-1:0] cur_track_q, tgt_q;
    logic [3:0]         sector_q;
    logic [31:0]        lba_q;

    logic               ack_rise, ack_fall, last_sector, need_load, wr_hit, dirty_now;
    logic [3:0]         sector_inc;

    function automatic logic [31:0] lba_of(input logic [TRACK_W-1:0] t, input logic [3:0] s);
        return 32'(SECTORS) * 32'(t) + 32'(s);
    endfunction

    assign ack_rise    = sd.sd_ack & ~ack_q;
    assign ack_fall    = ~sd.sd_ack & ack_q;
    assign last_sector = (sector_q == LAST_SECTOR);
    assign sector_inc  = sector_q + 4'd1;
    // A mount pulse in the same cycle must not start a load from stale image state.
    assign need_load   = mounted_q & ~img_mounted & (~valid_q | (track != cur_track_q));
    assign wr_hit      = fd_write_disk & valid_q & ~ro_q;
    // A write landing in the trigger cycle still forces a write-back.
    assign dirty_now   = dirty_q | wr_hit;

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state_q     <= IDLE;
            ack_q       <= 1'b0;
            mounted_q   <= 1'b0;
            valid_q     <= 1'b0;
            ro_q        <= 1'b0;
            dirty_q     <= 1'b0;
            abort_q     <= 1'b0;
            cpu_wait_q  <= 1'b0;
            sd_rd_q     <= 1'b0;
            sd_wr_q     <= 1'b0;
            cur_track_q <= '0;
            tgt_q       <= '0;
            sector_q    <= 4'd0;
            lba_q       <= 32'd0;
        end else begin
            ack_q <= sd.sd_ack;
            case (state_q)
                IDLE: begin
                    if (wr_hit) dirty_q <= 1'b1;
                    if (need_load) begin
                        tgt_q      <= track;
                        sector_q   <= 4'd0;
                        cpu_wait_q <= 1'b1;
                        if (dirty_now) begin
                            state_q <= WB_REQ;
                            sd_wr_q <= 1'b1;
                            lba_q   <= lba_of(cur_track_q, 4'd0);
                        end else begin
                            state_q <= RD_REQ;
                            sd_rd_q <= 1'b1;
                            lba_q   <= lba_of(track, 4'd0);
                        end
                    end
                end
                WB_REQ: if (ack_rise) begin
                    sd_wr_q <= 1'b0;
                    state_q <= WB_XFER;
                end
                RD_REQ: if (ack_rise) begin
                    sd_rd_q <= 1'b0;
                    state_q <= RD_XFER;
                end
                WB_XFER: if (ack_fall) begin
                    if (abort_q) begin
                        abort_q    <= 1'b0;
                        sector_q   <= 4'd0;
                        cpu_wait_q <= 1'b0;
                        state_q    <= IDLE;
                    end else if (last_sector) begin
                        sector_q <= 4'd0;
                        dirty_q  <= 1'b0;
                        sd_rd_q  <= 1'b1;
                        lba_q    <= lba_of(tgt_q, 4'd0);
                        state_q  <= RD_REQ;
                    end else begin
                        sector_q <= sector_inc;
                        sd_wr_q  <= 1'b1;
                        lba_q    <= lba_of(cur_track_q, sector_inc);
                        state_q  <= WB_REQ;
                    end
                end
                RD_XFER: if (ack_fall) begin
                    if (abort_q) begin
                        abort_q    <= 1'b0;
                        sector_q   <= 4'd0;
                        cpu_wait_q <= 1'b0;
                        state_q    <= IDLE;
                    end else if (last_sector) begin
                        sector_q    <= 4'd0;
                        cur_track_q <= tgt_q;
                        valid_q     <= 1'b1;
                        cpu_wait_q  <= 1'b0;
                        state_q     <= IDLE;
                    end else begin
                        sector_q <= sector_inc;
                        sd_rd_q  <= 1'b1;
                        lba_q    <= lba_of(tgt_q, sector_inc);
                        state_q  <= RD_REQ;
                    end
                end
                default: state_q <= IDLE;
            endcase
            // Mount overrides anything above; an in-flight sector still finishes,
            // then abort_q returns the FSM to IDLE without committing the track.
            if (img_mounted) begin
                mounted_q <= (img_size != 64'd0);
                valid_q   <= 1'b0;
                dirty_q   <= 1'b0;
                if (img_size != 64'd0) ro_q <= img_readonly;
                if (state_q != IDLE) abort_q <= 1'b1;
            end
        end
    end

    assign sd.sd_lba     = lba_q;
    assign sd.sd_rd      = sd_rd_q;
    assign sd.sd_wr      = sd_wr_q;
    assign sd.buf_sector = sector_q;
    assign cpu_wait      = cpu_wait_q;
    assign dirty         = dirty_q;
endmodule

// File: tb/tb_floppy_track_loader.sv
module tb_floppy_track_loader;
    localparam int SECTORS = 13;
    localparam int TRACK_W = 6;

    logic               clk_sys = 1'b0;
    logic               reset = 1'b1;
    logic [TRACK_W-1:0] track = '0;
    logic               fd_write_disk = 1'b0;
    logic               img_mounted = 1'b0;
    logic [63:0]        img_size = 64'd0;
    logic               img_readonly = 1'b0;
    logic               cpu_wait, dirty;

    floppy_track_loader_if ifc();

    floppy_track_loader #(.SECTORS(SECTORS), .TRACK_W(TRACK_W)) dut (
        .clk_sys(clk_sys), .reset(reset), .track(track),
        .fd_write_disk(fd_write_disk), .img_mounted(img_mounted),
        .img_size(img_size), .img_readonly(img_readonly),
        .sd(ifc), .cpu_wait(cpu_wait), .dirty(dirty)
    );

    always #5 clk_sys = ~clk_sys;

    int n_cmp = 0;
    int n_err = 0;

    logic        log_wr[$];
    logic [31:0] log_lba[$];
    logic [3:0]  log_sec[$];
    logic        resp_busy = 1'b0;
    logic        skip_stable = 1'b0;

    typedef struct {
        logic               do_mount;
        logic               ro;
        logic               do_write;
        logic [TRACK_W-1:0] trk;
        logic               exp_dirty_mid;
        int                 nwr;
        int                 wr_base;
        int                 nrd;
        int                 rd_base;
    } vec_t;
    vec_t vecs[5];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        n_cmp++;
        n_err++;
        $display("FAIL %s: wait bound expired", name);
    endtask

    // SD model: one request seen -> ack rises next cycle, held 10 cycles.
    initial begin : sd_model
        logic [31:0] lba;
        logic [3:0]  sec;
        ifc.sd_ack = 1'b0;
        forever begin
            @(negedge clk_sys);
            if (!reset && (ifc.sd_rd || ifc.sd_wr)) begin
                resp_busy = 1'b1;
                lba = ifc.sd_lba;
                sec = ifc.buf_sector;
                log_wr.push_back(ifc.sd_wr);
                log_lba.push_back(lba);
                log_sec.push_back(sec);
                check("cpu_wait_at_req", {63'd0, cpu_wait}, 64'd1);
                @(negedge clk_sys);
                ifc.sd_ack = 1'b1;
                repeat (10) @(negedge clk_sys);
                if (!skip_stable) begin
                    check("addr_stable", {28'd0, ifc.sd_lba, ifc.buf_sector}, {28'd0, lba, sec});
                    check("req_dropped", {62'd0, ifc.sd_rd, ifc.sd_wr}, 64'd0);
                end
                ifc.sd_ack = 1'b0;
                resp_busy = 1'b0;
            end
        end
    end

    task automatic pulse_mount(input logic ro);
        img_readonly = ro;
        img_mounted = 1'b1;
        @(negedge clk_sys);
        img_mounted = 1'b0;
    endtask

    task automatic run_load(input string name);
        int cyc;
        cyc = 0;
        while (!cpu_wait && cyc < 50) begin
            @(negedge clk_sys);
            cyc++;
        end
        if (!cpu_wait) begin
            fail_now({name, "_start"});
            return;
        end
        cyc = 0;
        while (cpu_wait && cyc < 2000) begin
            @(negedge clk_sys);
            cyc++;
        end
        if (cpu_wait) fail_now({name, "_end"});
    endtask

    task automatic check_log(input string name, input int nwr, input int wr_base,
                             input int nrd, input int rd_base);
        int n;
        logic        ew;
        logic [31:0] el;
        logic [3:0]  es;
        n = log_lba.size();
        check({name, "_count"}, 64'(n), 64'(nwr + nrd));
        for (int i = 0; i < n && i < nwr + nrd; i++) begin
            if (i < nwr) begin
                ew = 1'b1; el = 32'(wr_base + i); es = 4'(i);
            end else begin
                ew = 1'b0; el = 32'(rd_base + i - nwr); es = 4'(i - nwr);
            end
            check($sformatf("%s_req%0d", name, i),
                  {27'd0, log_wr[i], log_lba[i], log_sec[i]}, {27'd0, ew, el, es});
        end
        log_wr.delete();
        log_lba.delete();
        log_sec.delete();
    endtask

    initial begin : main
        int cyc;
        //           mount ro    wr    trk    dmid  nwr wr_b nrd rd_b
        vecs[0] = '{1'b1, 1'b0, 1'b0, 6'd0, 1'b0, 0,  0,  13, 0};
        vecs[1] = '{1'b0, 1'b0, 1'b0, 6'd5, 1'b0, 0,  0,  13, 65};
        vecs[2] = '{1'b0, 1'b0, 1'b1, 6'd6, 1'b1, 13, 65, 13, 78};
        vecs[3] = '{1'b1, 1'b1, 1'b0, 6'd6, 1'b0, 0,  0,  13, 78};
        vecs[4] = '{1'b0, 1'b0, 1'b1, 6'd2, 1'b0, 0,  0,  13, 26};

        repeat (3) @(negedge clk_sys);
        check("rst_sd_rd", {63'd0, ifc.sd_rd}, 64'd0);
        check("rst_sd_wr", {63'd0, ifc.sd_wr}, 64'd0);
        check("rst_cpu_wait", {63'd0, cpu_wait}, 64'd0);
        check("rst_sd_lba", {32'd0, ifc.sd_lba}, 64'd0);
        check("rst_buf_sector", {60'd0, ifc.buf_sector}, 64'd0);
        check("rst_dirty", {63'd0, dirty}, 64'd0);
        reset = 1'b0;
        repeat (5) @(negedge clk_sys);
        check("unmounted_idle", {63'd0, cpu_wait}, 64'd0);

        img_size = 64'd143360;
        for (int i = 0; i < 5; i++) begin
            if (vecs[i].do_mount) begin
                track = vecs[i].trk;
                pulse_mount(vecs[i].ro);
            end else if (vecs[i].do_write) begin
                fd_write_disk = 1'b1;
                @(negedge clk_sys);
                fd_write_disk = 1'b0;
            end
            @(negedge clk_sys);
            check($sformatf("v%0d_dirty_mid", i), {63'd0, dirty}, {63'd0, vecs[i].exp_dirty_mid});
            track = vecs[i].trk;
            run_load($sformatf("v%0d", i));
            check($sformatf("v%0d_dirty_end", i), {63'd0, dirty}, 64'd0);
            check($sformatf("v%0d_req_idle", i), {62'd0, ifc.sd_rd, ifc.sd_wr}, 64'd0);
            check_log($sformatf("v%0d", i), vecs[i].nwr, vecs[i].wr_base, vecs[i].nrd, vecs[i].rd_base);
        end

        // Track change 3 -> 7 during the 4th sector of a track-3 load.
        track = 6'd3;
        pulse_mount(1'b0);
        cyc = 0;
        while (log_lba.size() < 4 && cyc < 500) begin
            @(negedge clk_sys);
            cyc++;
        end
        if (log_lba.size() < 4) fail_now("mid_fourth_sector");
        track = 6'd7;
        run_load("mid_a");
        check_log("mid_a", 0, 0, 13, 39);
        run_load("mid_b");
        check_log("mid_b", 0, 0, 13, 91);

        // Reset while the second sector of a track-1 load is in RD_XFER.
        track = 6'd1;
        pulse_mount(1'b0);
        cyc = 0;
        while (!(log_lba.size() >= 2 && ifc.sd_ack) && cyc < 500) begin
            @(negedge clk_sys);
            cyc++;
        end
        if (!(log_lba.size() >= 2 && ifc.sd_ack)) fail_now("rst_reach_xfer");
        repeat (3) @(negedge clk_sys);
        skip_stable = 1'b1;
        reset = 1'b1;
        @(negedge clk_sys);
        check("mrst_sd_rd", {63'd0, ifc.sd_rd}, 64'd0);
        check("mrst_cpu_wait", {63'd0, cpu_wait}, 64'd0);
        check("mrst_buf_sector", {60'd0, ifc.buf_sector}, 64'd0);
        repeat (2) @(negedge clk_sys);
        reset = 1'b0;
        cyc = 0;
        while (resp_busy && cyc < 50) begin
            @(negedge clk_sys);
            cyc++;
        end
        if (resp_busy) fail_now("rst_ack_drain");
        skip_stable = 1'b0;
        log_wr.delete();
        log_lba.delete();
        log_sec.delete();
        repeat (5) @(negedge clk_sys);
        check("post_rst_idle", {63'd0, cpu_wait}, 64'd0);
        pulse_mount(1'b0);
        run_load("reload");
        check_log("reload", 0, 0, 13, 13);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
